// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start/data/parity/stop FSM,
// and a one-word output register with valid/ready handshake and overrun pulse.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned DATA_BITS    = 7,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_MODE == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic                   rx_meta, rx_s;
    logic                   armed, armed_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic [BW-1:0]          bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   data_sh, data_sh_next;
    logic                   par_bit, par_bit_next;
    logic                   ferr_acc, ferr_acc_next;
    logic                   done_c;
    logic                   done_ferr_c;
    logic                   done_perr_c;

    // Two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_bit;
            rx_s    <= rx_meta;
        end
    end

    // FSM state and frame datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= '0;
            data_sh  <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            state    <= state_next;
            armed    <= armed_next;
            cnt      <= cnt_next;
            bit_cnt  <= bit_next;
            data_sh  <= data_sh_next;
            par_bit  <= par_bit_next;
            ferr_acc <= ferr_acc_next;
        end
    end

    // Next-state, sample strobes and frame completion
    always_comb begin
        state_next    = state;
        armed_next    = armed;
        cnt_next      = cnt + CW'(1);
        bit_next      = bit_cnt;
        data_sh_next  = data_sh;
        par_bit_next  = par_bit;
        ferr_acc_next = ferr_acc;
        done_c        = 1'b0;
        done_ferr_c   = ferr_acc | ~rx_s;

        case (state)
            S_IDLE: begin
                cnt_next      = '0;
                bit_next      = '0;
                ferr_acc_next = 1'b0;
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    state_next = S_START;
                    armed_next = 1'b0;
                end
            end
            S_START: begin
                if (cnt == HALF_TICK) begin
                    cnt_next = '0;
                    bit_next = '0;
                    if (rx_s) begin
                        // start bit vanished: glitch, line is high so re-arm at once
                        state_next = S_IDLE;
                        armed_next = 1'b1;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt == FULL_TICK) begin
                    cnt_next     = '0;
                    data_sh_next = {rx_s, data_sh[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_next   = '0;
                        state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt == FULL_TICK) begin
                    cnt_next     = '0;
                    par_bit_next = rx_s;
                    state_next   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == FULL_TICK) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        ferr_acc_next = 1'b1;
                    end
                    if (bit_cnt == LAST_STOP) begin
                        // a low final stop sample (break) leaves IDLE disarmed
                        done_c     = 1'b1;
                        bit_next   = '0;
                        state_next = S_IDLE;
                        armed_next = rx_s;
                    end else begin
                        bit_next = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                armed_next = 1'b0;
                cnt_next   = '0;
                bit_next   = '0;
            end
        endcase
    end

    // Parity check over received data plus parity bit
    always_comb begin
        done_perr_c = 1'b0;
        if (PARITY_MODE != 0) begin
            done_perr_c = (^data_sh) ^ par_bit ^ PAR_ODD;
        end
    end

    // One-word output register with handshake and overrun detection
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_c) begin
                if (!data_valid || data_ready) begin
                    data_out   <= data_sh;
                    data_valid <= 1'b1;
                    parity_err <= done_perr_c;
                    frame_err  <= done_ferr_c;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (even parity / odd parity /
// 9 data bits with 2 stop bits) at 16 clocks per bit.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] rdy;

    logic [6:0] d0, d1;
    logic [8:0] d2;
    logic [2:0] dv, pe, fe, ov;
    logic [8:0] dw [3];

    int   n_tests = 0;
    int   n_fail  = 0;

    // monitor state
    bit   [2:0] dv_q;
    int         nrx   [3];
    int         nvcyc [3];
    int         nov   [3];
    logic [8:0] cap_d [3];
    logic [2:0] cap_pe, cap_fe;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx_bit(rx[0]), .data_out(d0), .data_valid(dv[0]),
        .data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .rx_bit(rx[1]), .data_out(d1), .data_valid(dv[1]),
        .data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rx_bit(rx[2]), .data_out(d2), .data_valid(dv[2]),
        .data_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));

    assign dw[0] = {2'b00, d0};
    assign dw[1] = {2'b00, d1};
    assign dw[2] = d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each delivered word, valid cycles and overrun pulses
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            dv_q[i] <= (dv[i] === 1'b1);
            if (dv[i] === 1'b1) nvcyc[i] <= nvcyc[i] + 1;
            if (ov[i] === 1'b1) nov[i] <= nov[i] + 1;
            if (dv[i] === 1'b1 && !dv_q[i]) begin
                nrx[i]    <= nrx[i] + 1;
                cap_d[i]  <= dw[i];
                cap_pe[i] <= pe[i];
                cap_fe[i] <= fe[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int sel, input logic b);
        rx[sel] = b;
        repeat (CPB) @(negedge clk);
    endtask

    // start, nb data bits LSB first, optional parity, nstop stop bits of value stop_val
    task automatic send(input int sel, input logic [8:0] data, input int nb,
                        input bit has_par, input logic par, input int nstop, input logic stop_val);
        @(negedge clk);
        drive_bit(sel, 1'b0);
        for (int k = 0; k < nb; k++) drive_bit(sel, data[k]);
        if (has_par) drive_bit(sel, par);
        for (int s = 0; s < nstop; s++) drive_bit(sel, stop_val);
        rx[sel] = 1'b1;
    endtask

    task automatic sample_point;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_rx, base_vc, base_ov;
        rx  = 3'b111;
        rdy = 3'b111;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_valid", 32'(dv), 32'h0);
        check("reset_data0", 32'(d0), 32'h0);
        check("reset_flags", 32'({pe, fe}), 32'h0);
        check("reset_overrun", 32'(ov), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // case 1: 0x55 even parity 0, consumer ready
        base_rx = nrx[0]; base_vc = nvcyc[0];
        send(0, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c1_count", 32'(nrx[0] - base_rx), 32'd1);
        check("c1_data", 32'(cap_d[0]), 32'h55);
        check("c1_perr", 32'(cap_pe[0]), 32'h0);
        check("c1_ferr", 32'(cap_fe[0]), 32'h0);
        check("c1_valid_cycles", 32'(nvcyc[0] - base_vc), 32'd1);

        // case 2: 0x07 with wrong even parity; odd instance with parity 0 is clean
        send(0, 9'h007, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c2_data", 32'(cap_d[0]), 32'h07);
        check("c2_perr_even", 32'(cap_pe[0]), 32'h1);
        base_rx = nrx[1];
        send(1, 9'h007, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c2_odd_count", 32'(nrx[1] - base_rx), 32'd1);
        check("c2_odd_data", 32'(cap_d[1]), 32'h07);
        check("c2_perr_odd", 32'(cap_pe[1]), 32'h0);

        // case 3: 0x2A with low stop bit, break, then clean 0x11
        base_rx = nrx[0];
        send(0, 9'h02A, 7, 1'b1, 1'b1, 1, 1'b0);
        rx[0] = 1'b0;
        idle(40);
        rx[0] = 1'b1;
        idle(30); sample_point;
        check("c3_count_break", 32'(nrx[0] - base_rx), 32'd1);
        check("c3_data", 32'(cap_d[0]), 32'h2A);
        check("c3_ferr", 32'(cap_fe[0]), 32'h1);
        check("c3_perr", 32'(cap_pe[0]), 32'h0);
        send(0, 9'h011, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c3_count_after", 32'(nrx[0] - base_rx), 32'd2);
        check("c3_clean_data", 32'(cap_d[0]), 32'h11);
        check("c3_clean_flags", 32'({cap_pe[0], cap_fe[0]}), 32'h0);

        // case 4: 5-cycle glitch while idle
        base_rx = nrx[0];
        @(negedge clk);
        rx[0] = 1'b0;
        idle(5);
        rx[0] = 1'b1;
        idle(40); sample_point;
        check("c4_count", 32'(nrx[0] - base_rx), 32'd0);
        check("c4_valid", 32'(dv[0]), 32'h0);
        check("c4_flags", 32'({pe[0], fe[0]}), 32'h0);
        check("c4_then_frame", 32'(d0), 32'h11);

        // case 5: consumer stalled, second frame overruns
        rdy[0] = 1'b0;
        base_ov = nov[0];
        send(0, 9'h012, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c5_first_valid", 32'(dv[0]), 32'h1);
        check("c5_first_data", 32'(d0), 32'h12);
        send(0, 9'h034, 7, 1'b1, 1'b1, 1, 1'b1);
        idle(20); sample_point;
        check("c5_held_data", 32'(d0), 32'h12);
        check("c5_held_valid", 32'(dv[0]), 32'h1);
        check("c5_overrun_pulses", 32'(nov[0] - base_ov), 32'd1);
        @(negedge clk);
        rdy[0] = 1'b1;
        sample_point;
        check("c5_valid_drop", 32'(dv[0]), 32'h0);
        check("c5_data_kept", 32'(d0), 32'h12);

        // case 6: reset in the middle of 0x7F data bits
        base_rx = nrx[0];
        @(negedge clk);
        drive_bit(0, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(0, 1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("c6_rst_data", 32'(d0), 32'h0);
        check("c6_rst_valid", 32'(dv[0]), 32'h0);
        check("c6_rst_flags", 32'({pe[0], fe[0], ov[0]}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rx[0] = 1'b1;
        idle(200);
        send(0, 9'h003, 7, 1'b1, 1'b0, 1, 1'b1);
        idle(20); sample_point;
        check("c6_count", 32'(nrx[0] - base_rx), 32'd1);
        check("c6_data", 32'(cap_d[0]), 32'h03);

        // 9 data bits, 2 stop bits: 0x1A5 has five ones, even parity bit 1
        base_rx = nrx[2]; base_vc = nvcyc[2];
        send(2, 9'h1A5, 9, 1'b1, 1'b1, 2, 1'b1);
        idle(20); sample_point;
        check("w9_count", 32'(nrx[2] - base_rx), 32'd1);
        check("w9_data", 32'(cap_d[2]), 32'h1A5);
        check("w9_flags", 32'({cap_pe[2], cap_fe[2]}), 32'h0);
        check("w9_valid_cycles", 32'(nvcyc[2] - base_vc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
